args_mst: RTL and testbench

ARGS_MST -- requirements
Module: args_mst

---
 rtl/args_pkg.sv | 16 +
 rtl/args_mst.sv | 141 ++++++++++++++
 tb/tb_args_mst.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/args_pkg.sv
// Shared definitions for the args_mst command-to-register-bus bridge:
// FSM state encoding and command opcode constants.
package args_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        RSP  = 3'd4
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/args_mst.sv
// Single-outstanding command master driving a simple register bus (wen/ren).
// Optional write read-back check is enabled by defining ARGS_MST_RDBK_EN.
//
// Handshakes: a channel transfer happens on a rising edge where valid and ready
// are both 1; the command is only taken in IDLE, and rsp_valid with
// rsp_data/rsp_err stays stable until rsp_ready is seen.
module args_mst
    import args_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RL = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          ren,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output state_t        o_dbg_state
);

    localparam int CW = (RL > 0) ? $clog2(RL + 1) : 1;

    state_t        r_state;
    state_t        w_next;
    logic          w_capture;
    logic          w_last_wait;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_rsp_data;
`ifdef ARGS_MST_RDBK_EN
    logic          r_wr;
    logic          r_rsp_err;
`endif

    assign w_last_wait = (r_cnt == CW'(RL - 1));

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        wen       = 1'b0;
        ren       = 1'b0;
        rsp_valid = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = (cmd_wr == OP_WR) ? WR : RD;
            end
            WR: begin
                wen = 1'b1;
`ifdef ARGS_MST_RDBK_EN
                w_next = RD;
`else
                w_next = RSP;
`endif
            end
            RD: begin
                ren = 1'b1;
                if (RL == 0) begin
                    w_capture = 1'b1;
                    w_next    = RSP;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_last_wait) begin
                    w_capture = 1'b1;
                    w_next    = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Address/data are only latched in IDLE, so raddr/waddr stay stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
`ifdef ARGS_MST_RDBK_EN
            r_wr       <= 1'b0;
            r_rsp_err  <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && cmd_valid) begin
                r_addr <= cmd_addr;
                r_data <= cmd_data;
`ifdef ARGS_MST_RDBK_EN
                r_wr   <= cmd_wr;
`endif
            end
            if (r_state == RD)        r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
            if (r_state == WR) r_rsp_data <= r_data;
            if (w_capture) begin
                r_rsp_data <= rdata;
`ifdef ARGS_MST_RDBK_EN
                r_rsp_err  <= (r_wr == OP_WR) && (rdata != r_data);
`endif
            end
        end
    end

    assign waddr       = r_addr;
    assign raddr       = r_addr;
    assign wdata       = r_data;
    assign rsp_data    = r_rsp_data;
    assign o_dbg_state = r_state;
`ifdef ARGS_MST_RDBK_EN
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_args_mst.sv
// Directed bench for args_mst (RL=2) with a register-bus responder model;
// read-back scenarios are included when ARGS_MST_RDBK_EN is defined.
module tb_args_mst;
    import args_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    state_t        dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int wen_cnt  = 0;
    int ren_cnt  = 0;
    int overlap  = 0;

    args_mst #(.AW(AW), .DW(DW), .RL(RL)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata),
        .o_dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register responder: address 0x8 is a fixed ID register, address 0x10 keeps only
    // the low 16 bits; read data emerges RL=2 cycles after the ren cycle.
    logic [DW-1:0] mem [0:15];
    logic [DW-1:0] rd_d1;
    logic [DW-1:0] rd_d2;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return (a == 32'h8) ? 32'h1234_5678 : mem[a[5:2]];
    endfunction

    always @(posedge clk) begin
        rd_d1 <= ren ? rd_model(raddr) : 32'hBAD0_BAD0;
        rd_d2 <= rd_d1;
        if (wen) mem[waddr[5:2]] <= (waddr == 32'h10) ? (wdata & 32'h0000_FFFF) : wdata;
    end
    assign rdata = rd_d2;

    always @(negedge clk) begin
        if (wen) wen_cnt++;
        if (ren) ren_cnt++;
        if (wen && ren) overlap++;
    end

    // Checking and driver tasks
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_data  = d;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) check("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    int          cyc;
    int          w0;
    int          r0;
    logic        bb_wr   [3];
    logic [31:0] bb_addr [3];
    logic [31:0] bb_data [3];
    logic [31:0] bb_exp  [3];

    initial begin
        bb_wr   = '{1'b1, 1'b0, 1'b1};
        bb_addr = '{32'h14, 32'h14, 32'h18};
        bb_data = '{32'h1111_1111, 32'h0, 32'h2222_2222};
        bb_exp  = '{32'h1111_1111, 32'h1111_1111, 32'h2222_2222};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_wen", 64'(wen), 64'd0);
        check("rst_ren", 64'(ren), 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_raddr", 64'(raddr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Single write
        w0 = wen_cnt;
        send(1'b1, 32'h4, 32'hDEAD_BEEF);
        check("wr_wen", 64'(wen), 64'd1);
        check("wr_ren", 64'(ren), 64'd0);
        check("wr_waddr", 64'(waddr), 64'h4);
        check("wr_wdata", 64'(wdata), 64'hDEAD_BEEF);
        wait_rsp(cyc);
`ifdef ARGS_MST_RDBK_EN
        check("wr_latency", 64'(cyc), 64'd4);
`else
        check("wr_latency", 64'(cyc), 64'd1);
`endif
        check("wr_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
        check("wr_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        check("wr_back_idle", 64'(cmd_ready), 64'd1);
        check("wr_rsp_drop", 64'(rsp_valid), 64'd0);
        check("wr_one_pulse", 64'(wen_cnt - w0), 64'd1);

        // Read with RL=2: raddr stable through RD and both WAIT cycles
        r0 = ren_cnt;
        send(1'b0, 32'h8, 32'h0);
        check("rd_ren", 64'(ren), 64'd1);
        check("rd_wen", 64'(wen), 64'd0);
        check("rd_raddr0", 64'(raddr), 64'h8);
        @(negedge clk);
        check("rd_ren_w1", 64'(ren), 64'd0);
        check("rd_raddr1", 64'(raddr), 64'h8);
        check("rd_valid_w1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("rd_raddr2", 64'(raddr), 64'h8);
        check("rd_valid_w2", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("rd_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_data", 64'(rsp_data), 64'h1234_5678);
        check("rd_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        check("rd_back_idle", 64'(cmd_ready), 64'd1);
        check("rd_one_pulse", 64'(ren_cnt - r0), 64'd1);

        // Response back-pressure with a competing command
        rsp_ready = 1'b0;
        send(1'b1, 32'hC, 32'h0BAD_F00D);
        wait_rsp(cyc);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h4;
        w0 = wen_cnt;
        r0 = ren_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_data", 64'(rsp_data), 64'h0BAD_F00D);
            check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        check("stall_no_wen", 64'(wen_cnt - w0), 64'd0);
        check("stall_no_ren", 64'(ren_cnt - r0), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_idle", 64'(cmd_ready), 64'd1);
        check("stall_release_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pend_ren", 64'(ren), 64'd1);
        check("pend_raddr", 64'(raddr), 64'h4);
        wait_rsp(cyc);
        check("pend_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
        @(negedge clk);

        // Reset in WAIT aborts the read
        send(1'b0, 32'h8, 32'h0);
        @(negedge clk);
        check("abort_in_wait", 64'(dbg_state), 64'(WAIT));
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        check("abort_ren", 64'(ren), 64'd0);
        check("abort_wen", 64'(wen), 64'd0);
        check("abort_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        w0 = wen_cnt;
        r0 = ren_cnt;
        @(negedge clk);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (4) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        check("abort_no_wen", 64'(wen_cnt - w0), 64'd0);
        check("abort_no_ren", 64'(ren_cnt - r0), 64'd0);

        // Back-to-back commands with rsp_ready tied high
        w0 = overlap;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_wr    = bb_wr[i];
            cmd_addr  = bb_addr[i];
            cmd_data  = bb_data[i];
            if (i > 0) begin
                @(negedge clk);
                check("b2b_idle_ready", 64'(cmd_ready), 64'd1);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            check("b2b_accept_wen", 64'(wen), 64'(bb_wr[i]));
            check("b2b_accept_ren", 64'(ren), 64'(!bb_wr[i]));
            check("b2b_busy", 64'(cmd_ready), 64'd0);
            wait_rsp(cyc);
            check("b2b_rsp_data", 64'(rsp_data), 64'(bb_exp[i]));
        end
        @(negedge clk);
        check("b2b_no_overlap", 64'(overlap - w0), 64'd0);

`ifdef ARGS_MST_RDBK_EN
        // Read-back of a register that drops the upper half
        send(1'b1, 32'h10, 32'hFFFF_FFFF);
        wait_rsp(cyc);
        check("rdbk_rsp_data", 64'(rsp_data), 64'h0000_FFFF);
        check("rdbk_rsp_err", 64'(rsp_err), 64'd1);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
